// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MUL_LAT     = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_is_multi,
  input  logic        ex_branch_taken,
  input  logic        dmem_busy,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        mul_busy,
  output logic        mul_done,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, MULTI} state_t;

  // Cycles left in MULTI after the entry cycle, not counting the completion cycle.
  localparam logic [4:0] MUL_RELOAD = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;
  localparam logic [16:0] TIMEOUT_LIM = 17'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [4:0]  mul_cnt, mul_cnt_nxt;
  logic [15:0] mem_wait_cnt;
  logic        load_use;
  logic        timeout_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Flag on the busy cycle that brings the wait count up to the timeout.
  assign timeout_hit = dmem_busy && (({1'b0, mem_wait_cnt} + 17'd1) >= TIMEOUT_LIM);

  // Sequencer state and remaining multi-cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mul_cnt <= 5'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // Prioritised hazard resolution: freeze, multi-cycle, branch, load-use.
  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    flush_M     = 1'b0;
    mul_busy    = 1'b0;
    mul_done    = 1'b0;
    if (!rst) begin
      mul_busy = (state == MULTI);
      if (dmem_busy) begin
        // Whole pipe holds; pending bubbles are re-evaluated once memory is ready.
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (state == MULTI) begin
        if (mul_cnt != 5'd0) begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          stall_E     = 1'b1;
          flush_M     = 1'b1;
          mul_cnt_nxt = mul_cnt - 5'd1;
        end else begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end else if (ex_is_multi) begin
        // A multi-cycle op outranks a branch claimed in the same EX slot.
        if (MUL_LAT > 1) begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          stall_E     = 1'b1;
          flush_M     = 1'b1;
          state_nxt   = MULTI;
          mul_cnt_nxt = MUL_RELOAD;
        end else begin
          mul_done = 1'b1;
        end
      end else if (ex_branch_taken) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Consecutive busy-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wait_cnt <= 16'd0;
      mem_err      <= 1'b0;
    end else begin
      if (!dmem_busy) begin
        mem_wait_cnt <= 16'd0;
      end else if (mem_wait_cnt != 16'hFFFF) begin
        mem_wait_cnt <= mem_wait_cnt + 16'd1;
      end
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (stall_F && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        ex_is_load = 1'b0, ex_is_multi = 1'b0;
  logic        ex_branch_taken = 1'b0, dmem_busy = 1'b0;

  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M;
  logic        mul_busy, mul_done, mem_err;
  logic [31:0] stall_cycles;

  logic        u1_stall_F, u1_stall_D, u1_stall_E, u1_stall_M;
  logic        u1_flush_D, u1_flush_E, u1_flush_M;
  logic        u1_mul_busy, u1_mul_done, u1_mem_err;
  logic [31:0] u1_stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(3), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_is_multi(ex_is_multi),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .mul_busy(mul_busy), .mul_done(mul_done), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MUL_LAT(1), .MEM_TIMEOUT(255)) u_one (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_is_multi(ex_is_multi),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .stall_F(u1_stall_F), .stall_D(u1_stall_D), .stall_E(u1_stall_E), .stall_M(u1_stall_M),
    .flush_D(u1_flush_D), .flush_E(u1_flush_E), .flush_M(u1_flush_M),
    .mul_busy(u1_mul_busy), .mul_done(u1_mul_done), .mem_err(u1_mem_err),
    .stall_cycles(u1_stall_cycles)
  );

  // Expected-vector bit map
  localparam logic [12:0] SF = 13'h1000, SD = 13'h0800, SE = 13'h0400, SM = 13'h0200;
  localparam logic [12:0] FD = 13'h0100, FE = 13'h0080, FM = 13'h0040, BSY = 13'h0020;
  localparam logic [12:0] DN = 13'h0010, ERR = 13'h0008;
  localparam logic [12:0] U_SF = 13'h0004, U_FM = 13'h0002, U_DN = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] FRZ  = SF | SD | SE | SM | U_SF;
  localparam logic [12:0] MSTL = SF | SD | SE | FM;

  typedef struct {
    int          id;
    logic [12:0] ctrl;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          vec_id = 0;
  logic [31:0] exp_sc = 0;

  function automatic logic [12:0] act_ctrl();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M,
            mul_busy, mul_done, mem_err, u1_stall_F, u1_flush_M, u1_mul_done};
  endfunction

  task automatic check(input int id, input logic [12:0] want, input logic [31:0] want_sc);
    logic [12:0] got;
    got = act_ctrl();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL vec%0d ctrl got=%h want=%h", id, got, want);
    end
    total++;
    if (stall_cycles !== want_sc) begin
      bad++;
      $display("FAIL vec%0d stall_cycles got=%0d want=%0d", id, stall_cycles, want_sc);
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.id, e.ctrl, e.sc);
    end
  end

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic ld, input logic mul, input logic br, input logic bz,
                      input logic [12:0] want);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_is_load = ld; ex_is_multi = mul; ex_branch_taken = br; dmem_busy = bz;
    sb.push_back('{id: vec_id, ctrl: want, sc: exp_sc});
    vec_id++;
    if (want[12]) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [12:0] want);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, want);
  endtask

  task automatic pulse_reset();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_is_load = 1'b0; ex_is_multi = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;
    rst = 1'b1;
    exp_sc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    total++;
    if (act_ctrl() !== NONE) begin
      bad++;
      $display("FAIL in_reset ctrl got=%h want=%h", act_ctrl(), NONE);
    end
    rst = 1'b0;
    idle(NONE);

    // Load-use on rs2, then bubble gone
    step(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, SF | SD | FE | U_SF);
    idle(NONE);
    // Load into x0 never stalls
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // Load-use on rs1
    step(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, SF | SD | FE | U_SF);
    // Branch overrides load-use
    step(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, FD | FE);
    // Load without dependency
    step(5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, NONE);

    // Multi-cycle op, MUL_LAT=3 (and MUL_LAT=1 instance completes at once)
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MSTL | U_DN);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MSTL | BSY | U_DN);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BSY | DN | U_DN);
    idle(NONE);

    // Freeze for 4 cycles in the first MULTI cycle; timeout of 4 trips too
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MSTL | U_DN);
    for (int i = 0; i < 4; i++)
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, FRZ | BSY);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MSTL | BSY | ERR | U_DN);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BSY | DN | ERR | U_DN);
    idle(ERR);

    // Async reset in MULTI with mul_cnt=1
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MSTL | ERR | U_DN);
    #2;
    check(vec_id, MSTL | BSY | ERR | U_DN, exp_sc);
    vec_id++;
    rst = 1'b1;
    #1;
    exp_sc = 0;
    check(vec_id, NONE, 32'd0);
    vec_id++;
    ex_is_multi = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(NONE);
    idle(NONE);

    // Timeout: busy for 6 cycles, flag sticks afterwards
    for (int i = 0; i < 6; i++)
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, (i >= 4) ? (FRZ | ERR) : FRZ);
    idle(ERR);
    idle(ERR);
    pulse_reset();
    idle(NONE);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
